// File: rtl/pipe_stage_ctrl_if.sv
// Handshake and per-stage control bundle between a pipeline controller and its environment.
// The slave side is the controller; the master side drives upstream/downstream requests.
interface pipe_stage_ctrl_if #(
    parameter int STAGES = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_mc;
    logic              in_ready;
    logic              out_ready;
    logic              out_valid;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_clear;
    logic [STAGES-1:0] stage_valid;
    logic              mc_busy;

    modport master (
        output flush, in_valid, in_mc, out_ready,
        input  in_ready, out_valid, stage_en, stage_clear, stage_valid, mc_busy
    );

    modport slave (
        input  flush, in_valid, in_mc, out_ready,
        output in_ready, out_valid, stage_en, stage_clear, stage_valid, mc_busy
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Valid/stall controller for an enable/clear register pipeline with one multicycle stage.
// Bubbles collapse; a multicycle item parks in MC_STAGE until its counter drains.
module pipe_stage_ctrl #(
    parameter int STAGES   = 4,
    parameter int MC_STAGE = 1,
    parameter int MCYCLES  = 8
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_ctrl_if.slave bus
);

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_m;
    logic [7:0]        r_cnt;

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_ready;
    logic [STAGES-1:0] w_inv;
    logic [STAGES-1:0] w_min;
    logic              w_kill;
    logic              w_mc_load;

    always_comb begin
        w_hold           = '0;
        w_hold[MC_STAGE] = r_v[MC_STAGE] & r_m[MC_STAGE] & (r_cnt != 8'd0);

        // Ready ripples from the output back toward stage 0.
        w_ready             = '0;
        w_ready[STAGES-1]   = ~r_v[STAGES-1] | (bus.out_ready & ~w_hold[STAGES-1]);
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_ready[i] = ~r_v[i] | (w_ready[i+1] & ~w_hold[i]);
        end

        w_inv    = '0;
        w_min    = '0;
        w_inv[0] = bus.in_valid;
        w_min[0] = bus.in_mc;
        for (int i = 1; i < STAGES; i++) begin
            w_inv[i] = r_v[i-1] & ~w_hold[i-1];
            w_min[i] = r_m[i-1];
        end
    end

    assign w_kill    = reset | bus.flush;
    assign w_mc_load = w_ready[MC_STAGE] & w_inv[MC_STAGE] & w_min[MC_STAGE];

    always_comb begin
        if (w_kill) begin
            bus.in_ready    = 1'b0;
            bus.stage_en    = '1;
            bus.stage_clear = '1;
        end else begin
            bus.in_ready    = w_ready[0];
            bus.stage_en    = w_ready;
            bus.stage_clear = w_ready & ~w_inv;
        end
    end

    assign bus.stage_valid = r_v;
    assign bus.out_valid   = r_v[STAGES-1];
    assign bus.mc_busy     = (r_cnt != 8'd0);

    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_v   <= '0;
            r_m   <= '0;
            r_cnt <= 8'd0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_v[i] <= w_inv[i];
                    r_m[i] <= w_min[i] & w_inv[i];
                end
            end
            if (w_mc_load) begin
                r_cnt <= 8'(MCYCLES - 1);
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl (4 stages, multicycle stage 1, 8 cycles).
// A small data pipe driven by stage_en/stage_clear tracks item order.
module tb_pipe_stage_ctrl;
    localparam int STAGES   = 4;
    localparam int MC_STAGE = 1;
    localparam int MCYCLES  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_ctrl_if #(.STAGES(STAGES)) bus ();

    pipe_stage_ctrl #(
        .STAGES  (STAGES),
        .MC_STAGE(MC_STAGE),
        .MCYCLES (MCYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] in_data;
    logic [7:0] d [STAGES];
    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) begin
        if (bus.stage_en[0]) d[0] <= bus.stage_clear[0] ? 8'h00 : in_data;
        for (int i = 1; i < STAGES; i++) begin
            if (bus.stage_en[i]) d[i] <= bus.stage_clear[i] ? 8'h00 : d[i-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mc     = 1'b0;
        bus.out_ready = 1'b1;
        in_data       = 8'h00;

        // Reset outputs regardless of other inputs
        tick();
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_stage_en", 32'(bus.stage_en), 32'hf);
        chk("rst_stage_clear", 32'(bus.stage_clear), 32'hf);
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_valid", 32'(bus.stage_valid), 32'd0);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_mc_busy", 32'(bus.mc_busy), 32'd0);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = 8'(c + 1);
            #1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            chk("stream_out_valid", 32'(bus.out_valid), 32'(c >= 4));
            if (c >= 4) chk("stream_order", 32'(d[3]), 32'(c - 3));
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("stream_drained", 32'(bus.stage_valid), 32'd0);

        // Back-pressure fill and ordered retire
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            in_data      = 8'(16 + c);
            #1;
            chk("bp_fill_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        in_data = 8'h55;
        #1;
        chk("bp_full_valid", 32'(bus.stage_valid), 32'hf);
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_full_stage_en", 32'(bus.stage_en), 32'd0);
        chk("bp_full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_full_head", 32'(d[3]), 32'd16);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_head", 32'(d[3]), 32'd16);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_retire_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_retire_order", 32'(d[3]), 32'(16 + k));
            tick();
        end
        #1;
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Multicycle item followed by a non-mc item
        bus.out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bus.in_valid = (c <= 1);
            bus.in_mc    = (c == 0);
            in_data      = (c == 0) ? 8'hA0 : 8'hB0;
            #1;
            chk("mc_busy", 32'(bus.mc_busy), 32'(c >= 2 && c <= 8));
            chk("mc_out_valid", 32'(bus.out_valid), 32'(c == 11 || c == 12));
            if (c == 5) begin
                chk("mc_stall_valid", 32'(bus.stage_valid), 32'b0011);
                chk("mc_stall_en0", 32'(bus.stage_en[0]), 32'd0);
            end
            if (c == 11) chk("mc_first_out", 32'(d[3]), 32'hA0);
            if (c == 12) chk("mc_second_out", 32'(d[3]), 32'hB0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_mc    = 1'b0;

        // Bubble collapse behind a stalled head
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = (c == 0 || c == 3);
            in_data      = (c == 0) ? 8'hC1 : 8'hC2;
            #1;
            if (c >= 4) begin
                chk("bubble_valid", 32'(bus.stage_valid),
                    (c == 4) ? 32'b1001 : (c == 5) ? 32'b1010 : 32'b1100);
                chk("bubble_head", 32'(d[3]), 32'hC1);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("bubble_drain0", 32'(d[3]), 32'hC1);
        tick();
        #1;
        chk("bubble_drain1", 32'(d[3]), 32'hC2);
        repeat (3) tick();
        #1;
        chk("bubble_empty", 32'(bus.stage_valid), 32'd0);

        // Flush during multicycle hold with a new offer
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 0);
            bus.in_mc    = (c == 0);
            #1;
            if (c == 4) begin
                chk("fl_pre_busy", 32'(bus.mc_busy), 32'd1);
                chk("fl_pre_valid", 32'(bus.stage_valid), 32'b0010);
            end
            tick();
        end
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mc    = 1'b0;
        in_data      = 8'h77;
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fl_stage_en", 32'(bus.stage_en), 32'hf);
        chk("fl_stage_clear", 32'(bus.stage_clear), 32'hf);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_post_valid", 32'(bus.stage_valid), 32'd0);
        chk("fl_post_busy", 32'(bus.mc_busy), 32'd0);
        repeat (4) tick();
        #1;
        chk("fl_not_captured", 32'(bus.out_valid), 32'd0);

        // Reset with a full pipeline
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (4) tick();
        #1;
        chk("rf_full", 32'(bus.stage_valid), 32'hf);
        reset = 1'b1;
        #1;
        chk("rf_clear", 32'(bus.stage_clear), 32'hf);
        chk("rf_en", 32'(bus.stage_en), 32'hf);
        chk("rf_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rf_post_valid", 32'(bus.stage_valid), 32'd0);
        chk("rf_post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rf_post_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset (with flush) aborts a running multicycle op
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mc     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_mc    = 1'b0;
        tick();
        tick();
        #1;
        chk("rm_busy", 32'(bus.mc_busy), 32'd1);
        reset     = 1'b1;
        bus.flush = 1'b1;
        tick();
        reset     = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("rm_post_busy", 32'(bus.mc_busy), 32'd0);
        chk("rm_post_valid", 32'(bus.stage_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of pipeline register stages controlled (range 2..8).
REQ-002 SHALL have parameter MC_STAGE, default 1, index of the stage hosting multicycle operations (0..STAGES-1).
REQ-003 SHALL have parameter MCYCLES, default 8, cycles a multicycle op occupies MC_STAGE (range 1..255).
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  kill all in-flight items.
REQ-007 SHALL have port in_valid  input  1  upstream item offered to stage 0.
REQ-008 SHALL have port in_mc  input  1  offered item is multicycle; qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  stage 0 accepts the offered item this cycle.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the last-stage item.
REQ-011 SHALL have port out_valid  output  1  last stage holds a valid item.
REQ-012 SHALL have port stage_en  output  STAGES  enable for each stage's enable/clear pipeline register.
REQ-013 SHALL have port stage_clear  output  STAGES  clear for each stage register, effective only with stage_en.
REQ-014 SHALL have port stage_valid  output  STAGES  per-stage valid bits.
REQ-015 SHALL have port mc_busy  output  1  multicycle counter nonzero.

Function
REQ-016 SHALL keep per-stage registered state v[i] (valid) and m[i] (multicycle flag); stage_valid = v; out_valid = v[STAGES-1].
REQ-017 SHALL compute hold[i] = v[i] & m[i] & (cnt != 0) for i == MC_STAGE, else 0.
REQ-018 SHALL compute, combinationally from the last stage backward, ready[STAGES-1] = !v[STAGES-1] | (out_ready & !hold[STAGES-1]) and ready[i] = !v[i] | (ready[i+1] & !hold[i]).
REQ-019 SHALL define incoming valid: inv[0] = in_valid, inv[i] = v[i-1] & !hold[i-1].
REQ-020 SHALL, absent reset/flush: in_ready = ready[0]; stage_en[i] = ready[i]; stage_clear[i] = ready[i] & !inv[i] (bubble inserted as zeros).
REQ-021 SHALL, when stage_en[i], load v[i] <= inv[i] and m[i] <= (i==0 ? in_mc : m[i-1]) & inv[i]; otherwise v[i], m[i] hold.
REQ-022 SHALL collapse bubbles: an empty stage accepts from its predecessor even while later stages are stalled.
REQ-023 SHALL load cnt <= MCYCLES-1 on the edge where MC_STAGE loads an item with incoming m set; otherwise decrement cnt when nonzero; cnt never wraps below 0.
REQ-024 SHALL keep a multicycle item in MC_STAGE exactly MCYCLES cycles when downstream is ready, longer if downstream stalls.
REQ-025 SHALL give latency: item accepted in cycle c shows out_valid in cycle c+STAGES (non-mc) or c+STAGES+MCYCLES-1 (mc), with out_ready held high.
REQ-026 SHALL preserve order; no item duplicated or dropped except by flush/reset.
REQ-027 SHALL hold out_valid and last-stage register contents stable while out_valid & !out_ready.
REQ-028 SHALL, on flush (not reset), drive in_ready=0, stage_en all 1, stage_clear all 1; next cycle all v, m = 0, cnt = 0; offered input dropped.
REQ-029 SHALL give flush priority over any simultaneous accept, advance, or counter load.
REQ-030 SHALL drive mc_busy = (cnt != 0).

Reset
REQ-031 SHALL, while reset high, drive in_ready=0, stage_en all 1, stage_clear all 1, regardless of other inputs.
REQ-032 SHALL, after reset, have v=0, m=0, cnt=0; thus stage_valid=0, out_valid=0, mc_busy=0, in_ready=1.
REQ-033 SHALL abort any in-flight multicycle op when reset asserts mid-operation; reset overrides flush.

Verification
REQ-034 SHALL verify streaming: in_valid=1, out_ready=1, in_mc=0 from cycle 0 -> out_valid first high cycle 4, then high every cycle, in_ready always 1.
REQ-035 SHALL verify back-pressure: fill 4 items with out_ready=0 -> stage_valid=4'b1111, in_ready=0, stage_en=0; raise out_ready -> one item retires per cycle, order preserved.
REQ-036 SHALL verify multicycle: single item in_mc=1 accepted cycle 0, out_ready=1 -> mc_busy high cycles 2..8, out_valid cycle 11; a following non-mc item stalls behind it in stage 0.
REQ-037 SHALL verify bubble collapse: items at stages 0 and 3, out_ready=0 -> stage 0 item advances to stages 1,2 while stage 3 holds.
REQ-038 SHALL verify flush during multicycle hold with in_valid=1 -> next cycle stage_valid=0, mc_busy=0, offered item not captured.
REQ-039 SHALL verify reset asserted with pipeline full -> stage_clear all 1 during reset; after release stage_valid=0, in_ready=1.
